// File: rtl/rgb_pixel_convert_if.sv
// Pixel stream bundle: valid/ready handshake, pixel word and sof/eol sideband.
// The master drives the pixel toward the slave; the slave returns ready.
interface rgb_pixel_convert_if #(
  parameter int W = 24
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] pixel;
  logic         sof;
  logic         eol;

  modport master (output valid, output pixel, output sof, output eol, input ready);
  modport slave  (input valid, input pixel, input sof, input eol, output ready);
endinterface

// File: rtl/rgb_pixel_convert.sv
// Streaming RGB colour-depth converter with optional R/B swap.
// Each channel is reduced from IN_CW to OUT_CW bits by truncation, rounding
// or 2x2 ordered dithering. A single output register gives one cycle of
// latency and full throughput. sat_cnt counts clipped pixels since the last sof.
module rgb_pixel_convert #(
  parameter int IN_CW   = 8,
  parameter int OUT_CW  = 4,
  parameter int SWAP_RB = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  rgb_pixel_convert_if.slave   in_bus,
  rgb_pixel_convert_if.master  out_bus,
  output logic [15:0]          sat_cnt
);

  localparam int S = IN_CW - OUT_CW;
  localparam logic [IN_CW:0] ONE_W     = {{IN_CW{1'b0}}, 1'b1};
  localparam logic [IN_CW:0] ROUND_ADD = ONE_W << (S - 1);

  // Dither matrix lookup; row y=0 is {0,2}, row y=1 is {3,1}.
  function automatic logic [1:0] bayer_val(input logic x, input logic y);
    logic [1:0] v;
    case ({y, x})
      2'b00:   v = 2'd0;
      2'b01:   v = 2'd2;
      2'b10:   v = 2'd3;
      2'b11:   v = 2'd1;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // One channel: returns {clipped, value}. The sum is one bit wider than the
  // input so the carry out of a round/dither add shows up as a clip.
  function automatic logic [OUT_CW:0] conv_ch(input logic [IN_CW-1:0] c,
                                              input logic [1:0]       m,
                                              input logic [1:0]       bval);
    logic [IN_CW:0]  add_v;
    logic [IN_CW:0]  sum_v;
    logic [OUT_CW:0] shr_v;
    logic [OUT_CW:0] res;
    case (m)
      2'd1:    add_v = ROUND_ADD;
      2'd2:    add_v = {{(IN_CW - 1){1'b0}}, bval} << (S - 2);
      default: add_v = {(IN_CW + 1){1'b0}};
    endcase
    sum_v = {1'b0, c} + add_v;
    shr_v = sum_v[IN_CW:S];
    if (shr_v[OUT_CW]) begin
      res = {1'b1, {OUT_CW{1'b1}}};
    end else begin
      res = {1'b0, shr_v[OUT_CW-1:0]};
    end
    return res;
  endfunction

  logic                  out_valid_r;
  logic [3*OUT_CW-1:0]   out_pixel_r;
  logic                  out_sof_r;
  logic                  out_eol_r;
  logic [15:0]           sat_cnt_r;
  logic                  x_par_r;
  logic                  y_par_r;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  x_eff_s;
  logic                  y_eff_s;
  logic [1:0]            bayer_s;
  logic [OUT_CW:0]       r_s;
  logic [OUT_CW:0]       g_s;
  logic [OUT_CW:0]       b_s;
  logic                  clip_any_s;
  logic [3*OUT_CW-1:0]   conv_pix_s;

  assign in_ready_s    = !out_valid_r || out_bus.ready;
  assign accept_s      = in_bus.valid && in_ready_s;
  assign in_bus.ready  = in_ready_s;
  assign out_bus.valid = out_valid_r;
  assign out_bus.pixel = out_pixel_r;
  assign out_bus.sof   = out_sof_r;
  assign out_bus.eol   = out_eol_r;
  assign sat_cnt       = sat_cnt_r;

  // Convert the incoming pixel using the parity it will be accepted at.
  always_comb begin
    x_eff_s    = x_par_r;
    y_eff_s    = y_par_r;
    if (in_bus.sof) begin
      x_eff_s = 1'b0;
      y_eff_s = 1'b0;
    end else begin
      x_eff_s = x_par_r;
      y_eff_s = y_par_r;
    end
    bayer_s    = bayer_val(x_eff_s, y_eff_s);
    r_s        = conv_ch(in_bus.pixel[3*IN_CW-1 -: IN_CW], mode, bayer_s);
    g_s        = conv_ch(in_bus.pixel[2*IN_CW-1 -: IN_CW], mode, bayer_s);
    b_s        = conv_ch(in_bus.pixel[IN_CW-1:0],          mode, bayer_s);
    clip_any_s = r_s[OUT_CW] | g_s[OUT_CW] | b_s[OUT_CW];
    if (SWAP_RB != 0) begin
      conv_pix_s = {b_s[OUT_CW-1:0], g_s[OUT_CW-1:0], r_s[OUT_CW-1:0]};
    end else begin
      conv_pix_s = {r_s[OUT_CW-1:0], g_s[OUT_CW-1:0], b_s[OUT_CW-1:0]};
    end
  end

  // Output register: load on accept, clear valid once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_pixel_r <= {(3*OUT_CW){1'b0}};
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_pixel_r <= conv_pix_s;
      out_sof_r   <= in_bus.sof;
      out_eol_r   <= in_bus.eol;
    end else if (out_bus.ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Position parity: sof restarts at (0,0); eol starts the next line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_par_r <= 1'b0;
      y_par_r <= 1'b0;
    end else if (accept_s) begin
      if (in_bus.eol) begin
        x_par_r <= 1'b0;
        y_par_r <= ~y_eff_s;
      end else begin
        x_par_r <= ~x_eff_s;
        y_par_r <= y_eff_s;
      end
    end
  end

  // Clipped-pixel counter, restarted by each sof pixel and saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= 16'd0;
    end else if (accept_s) begin
      if (in_bus.sof) begin
        sat_cnt_r <= {15'd0, clip_any_s};
      end else if (clip_any_s && (sat_cnt_r != 16'hFFFF)) begin
        sat_cnt_r <= sat_cnt_r + 16'd1;
      end
    end
  end

endmodule
